// File: rtl/cpu6502_pkg.sv
// Shared constants and types for the cpu6502 core: interrupt kinds, vector
// addresses, forced opcode and bus direction encoding.
package cpu6502_pkg;

  typedef enum logic [1:0] {
    INT_NONE  = 2'd0,
    INT_RESET = 2'd1,
    INT_NMI   = 2'd2,
    INT_IRQ   = 2'd3
  } int_kind_e;

  localparam logic [7:0] VEC_LO_NMI   = 8'hFA;
  localparam logic [7:0] VEC_LO_RESET = 8'hFC;
  localparam logic [7:0] VEC_LO_IRQ   = 8'hFE;
  localparam logic [7:0] VEC_HI       = 8'hFF;

  localparam logic [7:0] OPCODE_BRK = 8'h00;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Software BRK shares the IRQ vector.
  function automatic logic [7:0] vec_lo(input int_kind_e kind);
    case (kind)
      INT_RESET: vec_lo = VEC_LO_RESET;
      INT_NMI:   vec_lo = VEC_LO_NMI;
      default:   vec_lo = VEC_LO_IRQ;
    endcase
  endfunction

endpackage

// File: rtl/cpu6502_sync_edge.sv
// N-stage synchroniser for an active-low asynchronous request, with a
// registered one-cycle pulse on each falling edge of the synchronised level.
module cpu6502_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_async,
  output logic o_level,
  output logic o_fall
);

  logic cur_level;
  logic nxt_level;
  logic fall_q;
  logic fall_d;

  generate
    if (STAGES == 0) begin : g_bypass
      logic prev_q;

      // NOTE: every flop resets to a defined value; the chain idles high so
      // release from reset is not mistaken for a falling edge.
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) prev_q <= 1'b1;
        else            prev_q <= i_async;
      end

      assign cur_level = prev_q;
      assign nxt_level = i_async;
      assign o_level   = i_async;
    end else begin : g_sync
      logic [STAGES-1:0] sync_q;
      logic [STAGES-1:0] sync_d;

      // NOTE: always_comb assigns every output before any conditional
      // override so no latch can be inferred.
      always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = i_async;
      end

      // NOTE: sequential state uses non-blocking assignment so all flops
      // sample the pre-edge values, avoiding simulation races.
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) sync_q <= '1;
        else            sync_q <= sync_d;
      end

      assign cur_level = sync_q[STAGES-1];
      assign nxt_level = sync_d[STAGES-1];
      assign o_level   = cur_level;
    end
  endgenerate

  // Pulse coincides with the cycle the synchronised level first reads low.
  assign fall_d = cur_level & ~nxt_level;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) fall_q <= 1'b0;
    else            fall_q <= fall_d;
  end

  assign o_fall = fall_q;

endmodule

// File: rtl/cpu6502_timing_sequencer.sv
// Timing-control unit and instruction register: steps the T-state from the
// decoder, latches opcodes at T0 and injects forced BRK for RESET/NMI/IRQ.
module cpu6502_timing_sequencer
  import cpu6502_pkg::*;
#(
  parameter int TCU_WIDTH   = 4,
  parameter int TCU_MAX     = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [7:0]           i_data,
  input  logic [TCU_WIDTH-1:0] i_tcu_next,
  input  logic                 i_rw,
  input  logic                 i_rdy,
  input  logic                 i_nmi_n,
  input  logic                 i_irq_n,
  input  logic                 i_irq_mask,
  output logic [7:0]           o_ir,
  output logic [TCU_WIDTH-1:0] o_tcu,
  output logic                 o_sync,
  output logic [1:0]           o_int_kind,
  output logic [7:0]           o_vector_lo,
  output logic                 o_pc_inc_inhibit,
  output logic                 o_write_inhibit,
  output logic                 o_tcu_overflow
);

  logic [7:0]           ir_q, ir_d;
  logic [TCU_WIDTH-1:0] tcu_q, tcu_d;
  int_kind_e            int_kind_q, int_kind_d;
  logic [7:0]           vector_lo_q, vector_lo_d;
  logic                 reset_pending_q, reset_pending_d;
  logic                 nmi_pending_q, nmi_pending_d;
  logic                 overflow_q, overflow_d;

  logic      nmi_fall, irq_level;
  logic      nmi_level_unused, irq_fall_unused;
  logic      t0, stall, nmi_req, irq_req;
  int_kind_e sel_kind;

  cpu6502_sync_edge #(.STAGES(SYNC_STAGES)) u_nmi_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_async   (i_nmi_n),
    .o_level   (nmi_level_unused),
    .o_fall    (nmi_fall)
  );

  cpu6502_sync_edge #(.STAGES(SYNC_STAGES)) u_irq_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_async   (i_irq_n),
    .o_level   (irq_level),
    .o_fall    (irq_fall_unused)
  );

  assign t0    = (tcu_q == '0);
  // Only read cycles can be stretched; writes always complete.
  assign stall = ~i_rdy & (i_rw == RW_READ);

  // An edge landing in this very T0 is honoured without waiting a cycle.
  assign nmi_req = nmi_pending_q | nmi_fall;
  assign irq_req = ~irq_level & ~i_irq_mask;

  always_comb begin
    if (reset_pending_q)  sel_kind = INT_RESET;
    else if (nmi_req)     sel_kind = INT_NMI;
    else if (irq_req)     sel_kind = INT_IRQ;
    else                  sel_kind = INT_NONE;
  end

  always_comb begin
    ir_d            = ir_q;
    tcu_d           = tcu_q;
    int_kind_d      = int_kind_q;
    vector_lo_d     = vector_lo_q;
    reset_pending_d = reset_pending_q;
    nmi_pending_d   = nmi_pending_q | nmi_fall;
    overflow_d      = 1'b0;

    if (!stall) begin
      if (t0) begin
        int_kind_d  = sel_kind;
        vector_lo_d = vec_lo(sel_kind);
        ir_d        = (sel_kind == INT_NONE) ? i_data : OPCODE_BRK;
        if (sel_kind == INT_RESET) reset_pending_d = 1'b0;
        if (sel_kind == INT_NMI)   nmi_pending_d   = 1'b0;
      end

      // An out-of-range request ends the instruction and restarts at T0.
      if (i_tcu_next > TCU_WIDTH'(TCU_MAX)) begin
        tcu_d      = '0;
        overflow_d = 1'b1;
      end else begin
        tcu_d = i_tcu_next;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ir_q            <= OPCODE_BRK;
      tcu_q           <= '0;
      int_kind_q      <= INT_RESET;
      vector_lo_q     <= VEC_LO_RESET;
      reset_pending_q <= 1'b1;
      nmi_pending_q   <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      ir_q            <= ir_d;
      tcu_q           <= tcu_d;
      int_kind_q      <= int_kind_d;
      vector_lo_q     <= vector_lo_d;
      reset_pending_q <= reset_pending_d;
      nmi_pending_q   <= nmi_pending_d;
      overflow_q      <= overflow_d;
    end
  end

  assign o_ir             = ir_q;
  assign o_tcu            = tcu_q;
  assign o_sync           = t0;
  assign o_int_kind       = int_kind_q;
  assign o_vector_lo      = vector_lo_q;
  assign o_tcu_overflow   = overflow_q;
  assign o_pc_inc_inhibit = t0 & (sel_kind != INT_NONE);
  // RESET runs the BRK stack pushes as dummy reads.
  assign o_write_inhibit  = (int_kind_q == INT_RESET) &&
                            (tcu_q >= TCU_WIDTH'(2)) && (tcu_q <= TCU_WIDTH'(4));

endmodule

// File: tb/tb_cpu6502_timing_sequencer.sv
// Directed bench for cpu6502_timing_sequencer: reset BRK sequence, opcode
// load, NMI/IRQ injection, RDY stalls, TCU overflow and async reset.
module tb_cpu6502_timing_sequencer;

  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic [7:0] i_data;
  logic [3:0] i_tcu_next;
  logic       i_rw, i_rdy, i_nmi_n, i_irq_n, i_irq_mask;
  logic [7:0] o_ir;
  logic [3:0] o_tcu;
  logic       o_sync;
  logic [1:0] o_int_kind;
  logic [7:0] o_vector_lo;
  logic       o_pc_inc_inhibit, o_write_inhibit, o_tcu_overflow;

  int n_compared   = 0;
  int n_mismatched = 0;

  cpu6502_timing_sequencer #(.TCU_WIDTH(4), .TCU_MAX(7), .SYNC_STAGES(2)) dut (
    .i_clk            (i_clk),
    .i_reset_n        (i_reset_n),
    .i_data           (i_data),
    .i_tcu_next       (i_tcu_next),
    .i_rw             (i_rw),
    .i_rdy            (i_rdy),
    .i_nmi_n          (i_nmi_n),
    .i_irq_n          (i_irq_n),
    .i_irq_mask       (i_irq_mask),
    .o_ir             (o_ir),
    .o_tcu            (o_tcu),
    .o_sync           (o_sync),
    .o_int_kind       (o_int_kind),
    .o_vector_lo      (o_vector_lo),
    .o_pc_inc_inhibit (o_pc_inc_inhibit),
    .o_write_inhibit  (o_write_inhibit),
    .o_tcu_overflow   (o_tcu_overflow)
  );

  always #5 i_clk = ~i_clk;

  // Inputs change on the falling edge; outputs are sampled on the next one.
  task automatic cycle(input logic [3:0] nxt);
    i_tcu_next = nxt;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0; i_data = 8'h00; i_tcu_next = 4'd1; i_rw = 1'b1;
    i_rdy = 1'b1; i_nmi_n = 1'b1; i_irq_n = 1'b1; i_irq_mask = 1'b1;
    repeat (3) @(negedge i_clk);
    n_compared++;
    if (o_ir !== 8'h00) begin n_mismatched++; $display("FAIL rst_ir: got %h want 00", o_ir); end
    n_compared++;
    if (o_tcu !== 4'd0) begin n_mismatched++; $display("FAIL rst_tcu: got %0d want 0", o_tcu); end
    n_compared++;
    if (o_int_kind !== 2'd1) begin n_mismatched++; $display("FAIL rst_kind: got %0d want 1", o_int_kind); end
    n_compared++;
    if (o_vector_lo !== 8'hFC) begin n_mismatched++; $display("FAIL rst_vec: got %h want FC", o_vector_lo); end
    n_compared++;
    if (o_tcu_overflow !== 1'b0) begin n_mismatched++; $display("FAIL rst_ovf: got %b want 0", o_tcu_overflow); end
    n_compared++;
    if (o_sync !== 1'b1) begin n_mismatched++; $display("FAIL rst_sync: got %b want 1", o_sync); end
  endtask

  task automatic test_reset_brk();
    i_reset_n = 1'b1;
    n_compared++;
    if (o_pc_inc_inhibit !== 1'b1) begin n_mismatched++; $display("FAIL brk_t0_pcinh: got %b want 1", o_pc_inc_inhibit); end
    for (int t = 1; t <= 6; t++) begin
      cycle(4'(t));
      n_compared++;
      if (o_tcu !== 4'(t)) begin n_mismatched++; $display("FAIL brk_tcu[%0d]: got %0d want %0d", t, o_tcu, t); end
      n_compared++;
      if (o_write_inhibit !== (t >= 2 && t <= 4)) begin
        n_mismatched++; $display("FAIL brk_winh[%0d]: got %b want %b", t, o_write_inhibit, (t >= 2 && t <= 4));
      end
    end
    n_compared++;
    if (o_ir !== 8'h00 || o_int_kind !== 2'd1 || o_vector_lo !== 8'hFC) begin
      n_mismatched++; $display("FAIL brk_regs: got ir=%h kind=%0d vec=%h want ir=00 kind=1 vec=FC", o_ir, o_int_kind, o_vector_lo);
    end
    cycle(4'd0);
    n_compared++;
    if (o_write_inhibit !== 1'b0 || o_tcu !== 4'd0) begin
      n_mismatched++; $display("FAIL brk_end: got tcu=%0d winh=%b want tcu=0 winh=0", o_tcu, o_write_inhibit);
    end
  endtask

  task automatic test_normal_load();
    i_data = 8'hA9;
    n_compared++;
    if (o_pc_inc_inhibit !== 1'b0) begin n_mismatched++; $display("FAIL ld_pcinh: got %b want 0", o_pc_inc_inhibit); end
    cycle(4'd1);
    n_compared++;
    if (o_ir !== 8'hA9 || o_tcu !== 4'd1 || o_sync !== 1'b0) begin
      n_mismatched++; $display("FAIL ld_t1: got ir=%h tcu=%0d sync=%b want ir=A9 tcu=1 sync=0", o_ir, o_tcu, o_sync);
    end
    n_compared++;
    if (o_int_kind !== 2'd0 || o_vector_lo !== 8'hFE) begin
      n_mismatched++; $display("FAIL ld_kind: got kind=%0d vec=%h want kind=0 vec=FE", o_int_kind, o_vector_lo);
    end
    cycle(4'd0);
    n_compared++;
    if (o_sync !== 1'b1 || o_tcu !== 4'd0) begin
      n_mismatched++; $display("FAIL ld_sync: got sync=%b tcu=%0d want sync=1 tcu=0", o_sync, o_tcu);
    end
  endtask

  task automatic test_nmi_irq();
    i_data = 8'h00;
    cycle(4'd1); cycle(4'd2); cycle(4'd3);
    i_nmi_n = 1'b0; i_irq_n = 1'b0; i_irq_mask = 1'b0;
    cycle(4'd4); cycle(4'd5); cycle(4'd6); cycle(4'd0);
    n_compared++;
    if (o_pc_inc_inhibit !== 1'b1) begin n_mismatched++; $display("FAIL nmi_pcinh: got %b want 1", o_pc_inc_inhibit); end
    i_data = 8'hEA;
    cycle(4'd1);
    n_compared++;
    if (o_ir !== 8'h00 || o_int_kind !== 2'd2 || o_vector_lo !== 8'hFA) begin
      n_mismatched++; $display("FAIL nmi_take: got ir=%h kind=%0d vec=%h want ir=00 kind=2 vec=FA", o_ir, o_int_kind, o_vector_lo);
    end
    cycle(4'd2);
    n_compared++;
    if (o_write_inhibit !== 1'b0) begin n_mismatched++; $display("FAIL nmi_winh: got %b want 0", o_write_inhibit); end
    for (int t = 3; t <= 6; t++) cycle(4'(t));
    cycle(4'd0);
    n_compared++;
    if (o_pc_inc_inhibit !== 1'b1) begin n_mismatched++; $display("FAIL irq_pcinh: got %b want 1", o_pc_inc_inhibit); end
    cycle(4'd1);
    n_compared++;
    if (o_ir !== 8'h00 || o_int_kind !== 2'd3 || o_vector_lo !== 8'hFE) begin
      n_mismatched++; $display("FAIL irq_take: got ir=%h kind=%0d vec=%h want ir=00 kind=3 vec=FE", o_ir, o_int_kind, o_vector_lo);
    end
    // NMI stays low: no retrigger at the following T0.
    i_irq_n = 1'b1; i_irq_mask = 1'b1;
    for (int t = 2; t <= 6; t++) cycle(4'(t));
    cycle(4'd0);
    n_compared++;
    if (o_pc_inc_inhibit !== 1'b0) begin n_mismatched++; $display("FAIL nmi_hold_pcinh: got %b want 0", o_pc_inc_inhibit); end
    cycle(4'd1);
    n_compared++;
    if (o_ir !== 8'hEA || o_int_kind !== 2'd0) begin
      n_mismatched++; $display("FAIL nmi_hold_ld: got ir=%h kind=%0d want ir=EA kind=0", o_ir, o_int_kind);
    end
    i_nmi_n = 1'b1;
    cycle(4'd0);
  endtask

  task automatic test_rdy();
    i_data = 8'hAD;
    cycle(4'd1); cycle(4'd2);
    i_rdy = 1'b0; i_rw = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle(4'd3);
      n_compared++;
      if (o_tcu !== 4'd2) begin n_mismatched++; $display("FAIL rdy_hold[%0d]: got tcu=%0d want 2", k, o_tcu); end
    end
    i_rdy = 1'b1;
    cycle(4'd3);
    n_compared++;
    if (o_tcu !== 4'd3) begin n_mismatched++; $display("FAIL rdy_resume: got tcu=%0d want 3", o_tcu); end
    i_rdy = 1'b0; i_rw = 1'b0;
    cycle(4'd4);
    n_compared++;
    if (o_tcu !== 4'd4) begin n_mismatched++; $display("FAIL rdy_write: got tcu=%0d want 4", o_tcu); end
    cycle(4'd5);
    i_rdy = 1'b1; i_rw = 1'b1;
    cycle(4'd0);
    // Stall while in T0: opcode load must not happen.
    i_rdy = 1'b0; i_data = 8'h55;
    cycle(4'd1);
    n_compared++;
    if (o_tcu !== 4'd0 || o_ir !== 8'hAD) begin
      n_mismatched++; $display("FAIL rdy_t0: got tcu=%0d ir=%h want tcu=0 ir=AD", o_tcu, o_ir);
    end
    i_rdy = 1'b1;
    cycle(4'd1);
    n_compared++;
    if (o_ir !== 8'h55 || o_tcu !== 4'd1) begin
      n_mismatched++; $display("FAIL rdy_t0_load: got ir=%h tcu=%0d want ir=55 tcu=1", o_ir, o_tcu);
    end
    cycle(4'd0);
  endtask

  task automatic test_overflow();
    i_data = 8'hEA;
    cycle(4'd1);
    cycle(4'd9);
    n_compared++;
    if (o_tcu !== 4'd0 || o_tcu_overflow !== 1'b1) begin
      n_mismatched++; $display("FAIL ovf_fire: got tcu=%0d ovf=%b want tcu=0 ovf=1", o_tcu, o_tcu_overflow);
    end
    i_data = 8'hA9;
    cycle(4'd1);
    n_compared++;
    if (o_tcu_overflow !== 1'b0 || o_tcu !== 4'd1 || o_ir !== 8'hA9) begin
      n_mismatched++; $display("FAIL ovf_after: got ovf=%b tcu=%0d ir=%h want ovf=0 tcu=1 ir=A9", o_tcu_overflow, o_tcu, o_ir);
    end
  endtask

  task automatic test_async_reset();
    cycle(4'd2); cycle(4'd3); cycle(4'd4);
    #2 i_reset_n = 1'b0;
    #1;
    n_compared++;
    if (o_tcu !== 4'd0 || o_ir !== 8'h00) begin
      n_mismatched++; $display("FAIL areset: got tcu=%0d ir=%h want tcu=0 ir=00", o_tcu, o_ir);
    end
    n_compared++;
    if (o_int_kind !== 2'd1 || o_vector_lo !== 8'hFC) begin
      n_mismatched++; $display("FAIL areset_kind: got kind=%0d vec=%h want kind=1 vec=FC", o_int_kind, o_vector_lo);
    end
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1; i_data = 8'hA9;
    cycle(4'd1);
    n_compared++;
    if (o_ir !== 8'h00 || o_int_kind !== 2'd1 || o_tcu !== 4'd1) begin
      n_mismatched++; $display("FAIL areset_brk: got ir=%h kind=%0d tcu=%0d want ir=00 kind=1 tcu=1", o_ir, o_int_kind, o_tcu);
    end
  endtask

  initial begin
    test_reset();
    test_reset_brk();
    test_normal_load();
    test_nmi_irq();
    test_rdy();
    test_overflow();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/cpu6502_timing_sequencer.md
# cpu6502_timing_sequencer

Registered timing-control and instruction-register unit for the cpu6502 core. It owns the TCU state and the IR, and latches the opcode at the end of T0. It injects a forced BRK (opcode 8'h00) for RESET, NMI and IRQ, and freezes on RDY. It sits between the data bus and the combinational decoder: it drives the decoder's `i_ir` / `i_tcu` inputs and consumes the decoder's `o_tcu` next-state and `o_rw` outputs.

## Interface
Parameters:
- `TCU_WIDTH`, 4: width of the TCU state.
- `TCU_MAX`, 7: highest legal T-state. Any requested next state above this is an overflow.
- `SYNC_STAGES`, 2: synchroniser flops on `i_nmi_n` and `i_irq_n`. 0 means the inputs are already synchronous.

Ports:
- `i_clk`  in  1  Core clock. All state updates on the rising edge.
- `i_reset_n`  in  1  Reset. Asynchronous, active-low.
- `i_data`  in  8  Data bus, sampled as the opcode at the end of T0.
- `i_tcu_next`  in  TCU_WIDTH  Next T-state requested by the decoder.
- `i_rw`  in  1  Decoder read/write for the current cycle. 1 = read.
- `i_rdy`  in  1  Ready. 0 stalls read cycles.
- `i_nmi_n`  in  1  NMI request, falling-edge sensitive.
- `i_irq_n`  in  1  IRQ request, level sensitive.
- `i_irq_mask`  in  1  P register I flag.
- `o_ir`  out  8  Instruction register.
- `o_tcu`  out  TCU_WIDTH  Current T-state.
- `o_sync`  out  1  1 when `o_tcu`==0.
- `o_int_kind`  out  2  0 = none/BRK, 1 = RESET, 2 = NMI, 3 = IRQ.
- `o_vector_lo`  out  8  Vector low address: FC (RESET), FA (NMI), FE (IRQ/BRK).
- `o_pc_inc_inhibit`  out  1  Suppresses the T0 PC increment when a forced BRK is injected.
- `o_write_inhibit`  out  1  Converts stack pushes to reads during a RESET sequence.
- `o_tcu_overflow`  out  1  One-cycle pulse when the overflow recovery fires.

## Operation
- Reset values: `o_ir`=8'h00, `o_tcu`=0, `o_int_kind`=1, `o_vector_lo`=8'hFC, `reset_pending`=1, `nmi_pending`=0, `o_tcu_overflow`=0. The synchroniser flops reset to 1.
- Reset asserted mid-instruction aborts immediately. No partial state survives.
- T0 opcode load:
  - Selection is by priority RESET > NMI > IRQ > normal.
  - RESET: `reset_pending` set.
  - NMI: `nmi_pending` set.
  - IRQ: synchronised `irq_n`==0 and `i_irq_mask`==0, both sampled during T0.
  - Normal: no interrupt selected.
- Forced BRK: IR loads 8'h00, `o_int_kind` and `o_vector_lo` load per kind, and the corresponding pending flag clears. `o_pc_inc_inhibit`=1 combinationally throughout that T0.
- Normal load: IR loads `i_data`. `o_int_kind`=0, `o_vector_lo`=8'hFE.
- NMI detect: a falling edge of synchronised `nmi_n` sets `nmi_pending` in any T-state. An edge during an ongoing interrupt sequence stays pending and is taken at the next T0. A held-low NMI does not retrigger.
- TCU next state:
  - `o_tcu` <= `i_tcu_next` if ≤ TCU_MAX.
  - Otherwise `o_tcu` <= 0 and `o_tcu_overflow` pulses. IR is treated as ended.
- RDY: `i_rdy`==0 with `i_rw`==1 holds `o_tcu`, `o_ir` and all pending/kind registers. If the held state is T0, the opcode load is not performed.
  - RDY is ignored on write cycles (`i_rw`==0).
  - NMI edge detection continues during stall.
- `o_write_inhibit` = (`o_int_kind`==1) && (`o_tcu` in 2..4).

## Timing
- All outputs are registered except `o_sync`, `o_pc_inc_inhibit` and `o_write_inhibit`, which are combinational from registered state.
- Opcode latency: `i_data` valid at the T0 rising edge appears on `o_ir` with `o_tcu`=1 one cycle later.
- Interrupt latency:
  - `i_nmi_n` falling edge to `nmi_pending`: SYNC_STAGES+1 cycles.
  - Taken at the first T0 at or after that point.
- IRQ must be low at a T0 edge after synchronisation. Deasserting it before that T0 means it is not taken.
- Simultaneous NMI edge and IRQ at the same T0: NMI is taken. The IRQ is re-evaluated at the next T0.
- First cycle after reset release: T0 with forced BRK, `o_int_kind`=1.

## Structure
- Shared package `cpu6502_pkg` holds:
  - `INT_NONE`, `INT_RESET`, `INT_NMI`, `INT_IRQ`.
  - `VEC_LO_NMI`=8'hFA, `VEC_LO_RESET`=8'hFC, `VEC_LO_IRQ`=8'hFE, `VEC_HI`=8'hFF.
  - `OPCODE_BRK`=8'h00.
  - `RW_READ`=1, `RW_WRITE`=0.
- One sub-module, `cpu6502_sync_edge`: N-stage synchroniser with registered falling-edge pulse output. Instantiated for NMI; its level output is used for IRQ.

## Test plan
- Release reset with `i_tcu_next` following the T-state sequence 1..6 then 0 → first T0 shows `o_ir`=00, `o_int_kind`=1, `o_vector_lo`=FC. `o_write_inhibit`=1 exactly at TCU 2, 3, 4.
- Drive A9 on `i_data` at T0, decoder returns 0 at T1 → `o_ir`=A9, `o_tcu`=1, then `o_sync`=1 the next cycle. `o_pc_inc_inhibit` stays 0.
- NMI falling edge during T3 of a BRK sequence, IRQ low with mask 0 → next T0 injects NMI (FA). The following T0 injects IRQ (FE).
- `i_rdy`=0 for 3 cycles during T2 with `i_rw`=1 → `o_tcu` holds at 2 for 3 cycles. The same stall with `i_rw`=0 → `o_tcu` advances.
- `i_tcu_next`=9 with TCU_MAX=7 → `o_tcu`=0 next cycle and `o_tcu_overflow` is high for exactly 1 cycle.
- Assert `i_reset_n`=0 asynchronously at T4 of an instruction → `o_tcu`=0 and `o_ir`=00 immediately, without waiting for a clock edge.
